// File: rtl/serial_subtractor.sv
//------------------------------------------------------------------------------
// Module   : serial_subtractor
// Purpose  : Bit-serial N-bit subtractor (D = A - B - Bin), LSB first,
//            one full-subtractor cell plus a borrow flip-flop.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module serial_subtractor #(
  parameter int N     = 4,
  parameter int CNT_W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Bin,
  output logic [N-1:0] D,
  output logic         Bout,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(N - 1);

  state_t         state_q;
  logic [N-1:0]   a_sh_q;
  logic [N-1:0]   b_sh_q;
  logic           br_q;
  logic [CNT_W-1:0] cnt_q;
  logic [N-1:0]   d_q;
  logic           bout_q;
  logic           busy_q;
  logic           done_q;

  logic           a_bit;
  logic           b_bit;
  logic           diff_d;
  logic           borrow_d;

  // Full-subtractor cell on the current LSBs and the stored borrow.
  assign a_bit    = a_sh_q[0];
  assign b_bit    = b_sh_q[0];
  assign diff_d   = a_bit ^ b_bit ^ br_q;
  assign borrow_d = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      d_q     <= '0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_sh_q  <= A;
            b_sh_q  <= B;
            br_q    <= Bin;
            cnt_q   <= '0;
            d_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end

        S_RUN: begin
          d_q    <= {diff_d, d_q[N-1:1]};
          a_sh_q <= a_sh_q >> 1;
          b_sh_q <= b_sh_q >> 1;
          br_q   <= borrow_d;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (cnt_q == C_LAST_BIT) begin
            bout_q  <= borrow_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end

        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign D    = d_q;
  assign Bout = bout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
//------------------------------------------------------------------------------
// Module   : tb_serial_subtractor
// Purpose  : Self-checking bench for serial_subtractor (vector table, corner
//            sequences and random operations against an arithmetic model).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_serial_subtractor;

  localparam int N     = 4;
  localparam int CNT_W = 3;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         Bin;
  logic [N-1:0] D;
  logic         Bout;
  logic         busy;
  logic         done;

  int n_cmp;
  int n_err;

  serial_subtractor #(.N(N), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .D     (D),
    .Bout  (Bout),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         bin;
    logic [N-1:0] exp_d;
    logic         exp_bout;
  } vec_t;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Issue one operation from IDLE/DONE at a falling edge; returns at the
  // falling edge inside the DONE cycle (or after the cycle budget expires).
  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin,
                       input bit hold_start, input string nm);
    logic [N:0] ref_r;
    int busy_cnt;
    int done_at;
    ref_r = {1'b0, a} - {1'b0, b} - (N+1)'(bin);
    A = a; B = b; Bin = bin; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = hold_start;
    A = N'($urandom); B = N'($urandom); Bin = 1'($urandom);
    busy_cnt = 0;
    done_at  = 0;
    for (int i = 1; i <= N + 4; i++) begin
      if (done) begin
        done_at = i;
        break;
      end
      if (busy) busy_cnt++;
      @(negedge clk);
    end
    check({nm, " busy_cycles"}, busy_cnt, N);
    check({nm, " done_cycle"}, done_at, N + 1);
    check({nm, " busy_in_done"}, int'(busy), 0);
    check({nm, " D"}, int'(D), int'(ref_r[N-1:0]));
    check({nm, " Bout"}, int'(Bout), int'(ref_r[N]));
  endtask

  // One idle cycle: done must drop and the result must hold.
  task automatic idle_hold(input logic [N-1:0] exp_d, input logic exp_bo, input string nm);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check({nm, " idle_done"}, int'(done), 0);
    check({nm, " idle_busy"}, int'(busy), 0);
    check({nm, " idle_D"}, int'(D), int'(exp_d));
    check({nm, " idle_Bout"}, int'(Bout), int'(exp_bo));
  endtask

  initial begin
    vec_t vecs[5];
    logic [N-1:0] ra, rb;
    logic         rbin;
    logic [N:0]   rr;
    int           done_seen;

    n_cmp = 0;
    n_err = 0;
    vecs[0] = '{a: 4'd5,  b: 4'd3, bin: 1'b0, exp_d: 4'd2,  exp_bout: 1'b0};
    vecs[1] = '{a: 4'd3,  b: 4'd5, bin: 1'b0, exp_d: 4'd14, exp_bout: 1'b1};
    vecs[2] = '{a: 4'd0,  b: 4'd0, bin: 1'b1, exp_d: 4'd15, exp_bout: 1'b1};
    vecs[3] = '{a: 4'd9,  b: 4'd9, bin: 1'b0, exp_d: 4'd0,  exp_bout: 1'b0};
    vecs[4] = '{a: 4'd15, b: 4'd0, bin: 1'b0, exp_d: 4'd15, exp_bout: 1'b0};

    rst_n = 1'b0; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset D", int'(D), 0);
    check("reset Bout", int'(Bout), 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].bin, 1'b0, $sformatf("vec%0d", i));
      check($sformatf("vec%0d table_D", i), int'(D), int'(vecs[i].exp_d));
      check($sformatf("vec%0d table_Bout", i), int'(Bout), int'(vecs[i].exp_bout));
      idle_hold(vecs[i].exp_d, vecs[i].exp_bout, $sformatf("vec%0d", i));
    end

    // start held through RUN with new operands: result follows the captured ones
    do_op(4'd6, 4'd1, 1'b0, 1'b1, "hold_start");
    check("hold_start D", int'(D), 5);
    // start high in the DONE cycle: immediate back-to-back reload
    do_op(4'd7, 4'd2, 1'b0, 1'b0, "b2b");
    check("b2b D", int'(D), 5);
    check("b2b Bout", int'(Bout), 0);
    idle_hold(4'd5, 1'b0, "b2b");

    // leave a non-zero result with Bout=1 so the reset clear is visible
    do_op(4'd3, 4'd5, 1'b0, 1'b0, "pre_rst");
    idle_hold(4'd14, 1'b1, "pre_rst");

    // abort mid-RUN
    A = 4'd12; B = 4'd1; Bin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("abort first_run busy", int'(busy), 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort D", int'(D), 0);
    check("abort Bout", int'(Bout), 0);
    check("abort busy", int'(busy), 0);
    check("abort done", int'(done), 0);
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < N + 3; i++) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    check("abort no_done", done_seen, 0);

    // reset wins over start
    do_op(4'd10, 4'd3, 1'b1, 1'b0, "pre_rst2");
    rst_n = 1'b0; start = 1'b1; A = 4'd8; B = 4'd1;
    @(posedge clk);
    @(negedge clk);
    check("rst_start busy", int'(busy), 0);
    check("rst_start D", int'(D), 0);
    rst_n = 1'b1; start = 1'b0;
    @(negedge clk);
    check("rst_start stays_idle", int'(busy), 0);

    for (int i = 0; i < 40; i++) begin
      ra   = N'($urandom);
      rb   = N'($urandom);
      rbin = 1'($urandom);
      rr   = {1'b0, ra} - {1'b0, rb} - (N+1)'(rbin);
      do_op(ra, rb, rbin, 1'($urandom), $sformatf("rand%0d", i));
      if ($urandom_range(0, 1) == 0) idle_hold(rr[N-1:0], rr[N], $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
